// File: rtl/add_sub_n_inputs.sv
// Pops one word from every input FIFO, adds/subtracts per channel, shifts, then wraps or saturates.
// Latency 1 cycle pop-to-push; pops only when all inputs are non-empty and the result slot is free or draining.
module add_sub_n_inputs #(
   parameter int                NUM_IN     = 2,
   parameter int                DATA_WIDTH = 32,
   parameter logic [NUM_IN-1:0] SUB_MASK   = '0,
   parameter int                SHIFT      = 0,
   parameter bit                SATURATE   = 1'b0
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic [NUM_IN-1:0]            in_rd_en,
   input  logic [NUM_IN-1:0]            in_empty,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
   output logic                         out_wr_en,
   input  logic                         out_full,
   output logic [DATA_WIDTH-1:0]        out_din,
   output logic                         overflow
);

   localparam int SUM_W = DATA_WIDTH + $clog2(NUM_IN) + 1;
   localparam logic signed [SUM_W-1:0] MAX_V = (SUM_W'(1) << (DATA_WIDTH - 1)) - SUM_W'(1);
   localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    out_valid;
   logic                    fire;
   logic                    ovf;
   logic [DATA_WIDTH-1:0]   res;
   logic [DATA_WIDTH-1:0]   result;
   logic signed [DATA_WIDTH-1:0] x;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] sh;

   // Full-precision sum cannot overflow; range is checked only after the shift.
   always_comb begin
      x   = '0;
      sum = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         x = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
         if (SUB_MASK[i]) sum = sum - SUM_W'(x);
         else             sum = sum + SUM_W'(x);
      end
      sh     = sum >>> SHIFT;
      ovf    = (sh > MAX_V) || (sh < MIN_V);
      result = sh[DATA_WIDTH-1:0];
      if (SATURATE && ovf)
         result = sh[SUM_W-1] ? MIN_V[DATA_WIDTH-1:0] : MAX_V[DATA_WIDTH-1:0];
   end

   // Strobes are held low during reset so nothing is popped or pushed while state is cleared.
   always_comb begin
      out_valid = (state == HOLD);
      fire      = ~reset & ~(|in_empty) & (~out_valid | ~out_full);
      out_wr_en = ~reset & out_valid & ~out_full;
      in_rd_en  = {NUM_IN{fire}};
      state_nxt = state;
      case (state)
         EMPTY:   if (fire) state_nxt = HOLD;
         HOLD:    if (!fire && out_wr_en) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= EMPTY;
         res      <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (fire) begin
            res <= result;
            if (ovf) overflow <= 1'b1;
         end
      end
   end

   assign out_din = res;

endmodule

// File: tb/tb_add_sub_n_inputs.sv
// Bench for add_sub_n_inputs: three parameterisations, directed scenarios and a randomized scoreboard run.
module tb_add_sub_n_inputs;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // dut 0: defaults; dut 1: 3 inputs, 16 bit, saturate; dut 2: B subtracted, shift 1
   logic [1:0]  e0 = '1, rd0;
   logic [63:0] d0 = '0;
   logic        f0 = 1'b0, wr0, ov0;
   logic [31:0] o0;
   logic [2:0]  e1 = '1, rd1;
   logic [47:0] d1 = '0;
   logic        f1 = 1'b0, wr1, ov1;
   logic [15:0] o1;
   logic [1:0]  e2 = '1, rd2;
   logic [63:0] d2 = '0;
   logic        f2 = 1'b0, wr2, ov2;
   logic [31:0] o2;

   int n_c[3]    = '{2, 3, 2};
   int dw_c[3]   = '{32, 16, 32};
   int mask_c[3] = '{0, 0, 2};
   int sh_c[3]   = '{0, 0, 1};
   int sat_c[3]  = '{0, 1, 0};

   logic [7:0] s_rd;
   bit         s_wr;
   longint     s_dout;
   bit         s_ov;

   add_sub_n_inputs u0 (
      .clock(clock), .reset(reset), .in_rd_en(rd0), .in_empty(e0), .in_dout(d0),
      .out_wr_en(wr0), .out_full(f0), .out_din(o0), .overflow(ov0));

   add_sub_n_inputs #(.NUM_IN(3), .DATA_WIDTH(16), .SATURATE(1'b1)) u1 (
      .clock(clock), .reset(reset), .in_rd_en(rd1), .in_empty(e1), .in_dout(d1),
      .out_wr_en(wr1), .out_full(f1), .out_din(o1), .overflow(ov1));

   add_sub_n_inputs #(.SUB_MASK(2'b10), .SHIFT(1)) u2 (
      .clock(clock), .reset(reset), .in_rd_en(rd2), .in_empty(e2), .in_dout(d2),
      .out_wr_en(wr2), .out_full(f2), .out_din(o2), .overflow(ov2));

   // Reduce v to a dw-bit two's complement value.
   function automatic longint sx(longint v, int dw);
      longint m = (longint'(1) << dw) - 1;
      longint h = longint'(1) << (dw - 1);
      longint r = v & m;
      if (r >= h) r = r - (longint'(1) << dw);
      return r;
   endfunction

   // Reference: signed weighted sum, floor division by 2^shift, clamp or wrap.
   function automatic longint model(int d, longint x[8], output bit ov);
      longint s = 0;
      longint hi, lo, r;
      for (int i = 0; i < n_c[d]; i++) begin
         if (((mask_c[d] >> i) & 1) != 0) s = s - x[i];
         else                             s = s + x[i];
      end
      r  = s >>> sh_c[d];
      hi = (longint'(1) << (dw_c[d] - 1)) - 1;
      lo = -hi - 1;
      ov = (r > hi) || (r < lo);
      if (ov) begin
         if (sat_c[d] != 0) r = (r > hi) ? hi : lo;
         else               r = sx(r, dw_c[d]);
      end
      return r;
   endfunction

   task automatic drive(int d, logic [7:0] emp, longint x[8], bit full);
      case (d)
         0: begin
            e0 = emp[1:0]; f0 = full;
            for (int i = 0; i < 2; i++) d0[i*32 +: 32] = x[i][31:0];
         end
         1: begin
            e1 = emp[2:0]; f1 = full;
            for (int i = 0; i < 3; i++) d1[i*16 +: 16] = x[i][15:0];
         end
         default: begin
            e2 = emp[1:0]; f2 = full;
            for (int i = 0; i < 2; i++) d2[i*32 +: 32] = x[i][31:0];
         end
      endcase
   endtask

   task automatic sample(int d);
      case (d)
         0: begin s_rd = {6'b0, rd0}; s_wr = wr0; s_dout = longint'($signed(o0)); s_ov = ov0; end
         1: begin s_rd = {5'b0, rd1}; s_wr = wr1; s_dout = longint'($signed(o1)); s_ov = ov1; end
         default: begin s_rd = {6'b0, rd2}; s_wr = wr2; s_dout = longint'($signed(o2)); s_ov = ov2; end
      endcase
   endtask

   task automatic step(int d, logic [7:0] emp, longint a, longint b, longint c, bit full);
      longint x[8];
      foreach (x[i]) x[i] = 0;
      x[0] = a; x[1] = b; x[2] = c;
      @(negedge clock);
      drive(d, emp, x, full);
      #1;
      sample(d);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      e0 = '1; e1 = '1; e2 = '1;
      f0 = 1'b0; f1 = 1'b0; f2 = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(0, 8'h00, 1, 2, 0, 1'b0);
      tests++; if (s_rd !== 8'h00) begin fails++; $display("FAIL reset_rd got %h want 00", s_rd); end
      tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL reset_wr got %0d want 0", s_wr); end
      tests++; if (s_dout !== 0) begin fails++; $display("FAIL reset_dout got %0d want 0", s_dout); end
      tests++; if (s_ov !== 1'b0) begin fails++; $display("FAIL reset_ov got %0d want 0", s_ov); end
      step(1, 8'h00, 1, 2, 3, 1'b0);
      tests++; if (s_rd !== 8'h00) begin fails++; $display("FAIL reset_rd1 got %h want 00", s_rd); end
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      step(0, 8'h00, 5, -7, 0, 1'b0);
      tests++; if (s_rd !== 8'h03) begin fails++; $display("FAIL basic_rd got %h want 03", s_rd); end
      tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL basic_wr0 got %0d want 0", s_wr); end
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_wr !== 1'b1) begin fails++; $display("FAIL basic_wr1 got %0d want 1", s_wr); end
      tests++; if (s_dout !== -2) begin fails++; $display("FAIL basic_dout got %0d want -2", s_dout); end
      tests++; if (s_ov !== 1'b0) begin fails++; $display("FAIL basic_ov got %0d want 0", s_ov); end
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL basic_wr2 got %0d want 0", s_wr); end
   endtask

   task automatic test_wrap();
      do_reset();
      step(0, 8'h00, 'h7FFFFFFF, 1, 0, 1'b0);
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_dout !== -(longint'(1) << 31)) begin fails++; $display("FAIL wrap_dout got %0d want -2147483648", s_dout); end
      tests++; if (s_ov !== 1'b1) begin fails++; $display("FAIL wrap_ov got %0d want 1", s_ov); end
      for (int k = 0; k < 10; k++) begin
         step(0, 8'h00, k, 1, 0, 1'b0);
         tests++; if (s_ov !== 1'b1) begin fails++; $display("FAIL wrap_sticky[%0d] got %0d want 1", k, s_ov); end
         if (k > 0) begin
            tests++; if (s_dout !== k) begin fails++; $display("FAIL wrap_clean[%0d] got %0d want %0d", k, s_dout, k); end
         end
      end
      do_reset();
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_ov !== 1'b0) begin fails++; $display("FAIL wrap_ov_clear got %0d want 0", s_ov); end
   endtask

   task automatic test_saturate();
      do_reset();
      step(1, 8'h00, 30000, 10000, 0, 1'b0);
      step(1, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_dout !== 32767) begin fails++; $display("FAIL sat_hi got %0d want 32767", s_dout); end
      tests++; if (s_ov !== 1'b1) begin fails++; $display("FAIL sat_ov got %0d want 1", s_ov); end
      step(1, 8'h00, -30000, -10000, 0, 1'b0);
      step(1, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_dout !== -32768) begin fails++; $display("FAIL sat_lo got %0d want -32768", s_dout); end
   endtask

   task automatic test_sub_shift();
      do_reset();
      step(2, 8'h00, -3, 0, 0, 1'b0);
      step(2, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_dout !== -2) begin fails++; $display("FAIL subsh_a got %0d want -2", s_dout); end
      step(2, 8'h00, 9, 4, 0, 1'b0);
      step(2, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_dout !== 2) begin fails++; $display("FAIL subsh_b got %0d want 2", s_dout); end
      tests++; if (s_ov !== 1'b0) begin fails++; $display("FAIL subsh_ov got %0d want 0", s_ov); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(0, (k < 4) ? 8'h00 : 8'hFF, k + 1, 100 * k, 0, 1'b0);
         tests++; if (s_rd !== ((k < 4) ? 8'h03 : 8'h00)) begin fails++; $display("FAIL b2b_rd[%0d] got %h", k, s_rd); end
         tests++; if (s_wr !== (k >= 1)) begin fails++; $display("FAIL b2b_wr[%0d] got %0d want %0d", k, s_wr, k >= 1); end
         if (k >= 1) begin
            tests++; if (s_dout !== k + 100 * (k - 1)) begin fails++; $display("FAIL b2b_dout[%0d] got %0d want %0d", k, s_dout, k + 100 * (k - 1)); end
         end
      end
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL b2b_tail got %0d want 0", s_wr); end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(0, 8'h00, 11, 0, 0, 1'b1);
         tests++; if (s_rd !== ((k == 0) ? 8'h03 : 8'h00)) begin fails++; $display("FAIL bp_rd[%0d] got %h", k, s_rd); end
         tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL bp_wr[%0d] got %0d want 0", k, s_wr); end
      end
      step(0, 8'h00, 22, 0, 0, 1'b0);
      tests++; if (s_rd !== 8'h03) begin fails++; $display("FAIL bp_release_rd got %h want 03", s_rd); end
      tests++; if (s_wr !== 1'b1 || s_dout !== 11) begin fails++; $display("FAIL bp_release got wr=%0d dout=%0d want wr=1 dout=11", s_wr, s_dout); end
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_wr !== 1'b1 || s_dout !== 22) begin fails++; $display("FAIL bp_drain got wr=%0d dout=%0d want wr=1 dout=22", s_wr, s_dout); end
   endtask

   task automatic test_partial();
      do_reset();
      step(0, 8'h02, 1, 1, 0, 1'b0);
      tests++; if (s_rd !== 8'h00) begin fails++; $display("FAIL partial_b got %h want 00", s_rd); end
      step(0, 8'h01, 1, 1, 0, 1'b0);
      tests++; if (s_rd !== 8'h00) begin fails++; $display("FAIL partial_a got %h want 00", s_rd); end
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL partial_wr got %0d want 0", s_wr); end
   endtask

   task automatic test_reset_hold();
      longint z[8];
      foreach (z[i]) z[i] = 0;
      do_reset();
      step(0, 8'h00, 'h7FFFFFFF, 1, 0, 1'b1);
      tests++; if (s_rd !== 8'h03) begin fails++; $display("FAIL rh_pop got %h want 03", s_rd); end
      step(0, 8'hFF, 0, 0, 0, 1'b1);
      tests++; if (s_wr !== 1'b0 || s_ov !== 1'b1) begin fails++; $display("FAIL rh_hold got wr=%0d ov=%0d want wr=0 ov=1", s_wr, s_ov); end
      @(negedge clock);
      reset = 1'b1;
      #1; sample(0);
      tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL rh_in_reset_wr got %0d want 0", s_wr); end
      @(negedge clock);
      reset = 1'b0;
      drive(0, 8'hFF, z, 1'b0);
      #1; sample(0);
      tests++; if (s_wr !== 1'b0 || s_dout !== 0 || s_ov !== 1'b0) begin fails++; $display("FAIL rh_after got wr=%0d dout=%0d ov=%0d want 0/0/0", s_wr, s_dout, s_ov); end
      step(0, 8'hFF, 0, 0, 0, 1'b0);
      tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL rh_no_write got %0d want 0", s_wr); end
   endtask

   task automatic test_random(int d, int cycles);
      longint q[$];
      longint x[8];
      bit     ov_m = 1'b0;
      bit     o;
      logic [7:0] emp;
      logic [7:0] nmask = 8'((1 << n_c[d]) - 1);
      longint hi = (longint'(1) << (dw_c[d] - 1)) - 1;
      bit     full, fire_e, wr_e;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         emp = 8'hFF;
         foreach (x[i]) x[i] = 0;
         for (int i = 0; i < n_c[d]; i++) begin
            emp[i] = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
               0:       x[i] = hi;
               1:       x[i] = -hi - 1;
               default: x[i] = sx(longint'($urandom), dw_c[d]);
            endcase
         end
         full = ($urandom_range(0, 3) == 0);
         @(negedge clock);
         drive(d, emp, x, full);
         #1; sample(d);
         fire_e = ((emp & nmask) == 8'h00) && (q.size() == 0 || !full);
         wr_e   = (q.size() != 0) && !full;
         tests++; if (s_rd !== (fire_e ? nmask : 8'h00)) begin fails++; $display("FAIL rnd%0d_rd[%0d] got %h want %h", d, c, s_rd, fire_e ? nmask : 8'h00); end
         tests++; if (s_wr !== wr_e) begin fails++; $display("FAIL rnd%0d_wr[%0d] got %0d want %0d", d, c, s_wr, wr_e); end
         tests++; if (s_ov !== ov_m) begin fails++; $display("FAIL rnd%0d_ov[%0d] got %0d want %0d", d, c, s_ov, ov_m); end
         if (q.size() != 0) begin
            tests++; if (s_dout !== q[0]) begin fails++; $display("FAIL rnd%0d_dout[%0d] got %0d want %0d", d, c, s_dout, q[0]); end
         end
         if (wr_e) void'(q.pop_front());
         if (fire_e) begin
            q.push_back(model(d, x, o));
            ov_m = ov_m | o;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_saturate();
      test_sub_shift();
      test_back_to_back();
      test_backpressure();
      test_partial();
      test_reset_hold();
      test_random(0, 300);
      test_random(1, 300);
      test_random(2, 300);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
